ex_muldiv_stage: RTL and testbench

- Execute stage that feeds the MEM stage: produces ex_data (ALU result, effective address, or mul/div result), ex_data2 (store data) and the EX stall.
- Single-cycle ops pass through combinationally from the existing Alu result.
- RV64M multiply/divide ops run in an internal iterative mul/div engine; EX is held stalled until the result is ready.

---
 rtl/ex_muldiv_stage_pkg.sv | 39 +++
 rtl/ex_muldiv_stage_muldiv_unit.sv | 216 +++++++++++++++++++++
 rtl/ex_muldiv_stage.sv | 88 ++++++++
 tb/tb_ex_muldiv_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_stage_pkg.sv
// ex_muldiv_stage_pkg
//   Shared definitions for the execute stage and its iterative mul/div engine:
//   RV64M funct3 encodings, the mul/div engine state enum and the decoded
//   instruction fields the execute stage consumes.
package ex_muldiv_stage_pkg;

   localparam int MD_XLEN       = 64;
   localparam int MD_ITER_CNT_W = 7;

   // RV64M funct3 encodings (OP / OP-32 with funct7 = 0000001)
   localparam logic [2:0] F3M_MUL    = 3'b000;
   localparam logic [2:0] F3M_MULH   = 3'b001;
   localparam logic [2:0] F3M_MULHSU = 3'b010;
   localparam logic [2:0] F3M_MULHU  = 3'b011;
   localparam logic [2:0] F3M_DIV    = 3'b100;
   localparam logic [2:0] F3M_DIVU   = 3'b101;
   localparam logic [2:0] F3M_REM    = 3'b110;
   localparam logic [2:0] F3M_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_BUSY,
      MD_DONE
   } muldiv_state_t;

   typedef struct packed {
      logic       is_load;
      logic       is_store;
      logic       is_muldiv;
      logic [2:0] funct3;
      logic       alu_width_32;
   } decoded_inst_t;

   // All divide/remainder encodings have funct3[2] set
   function automatic logic f3IsDiv(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/ex_muldiv_stage_muldiv_unit.sv
// muldiv_unit
//   Iterative RV64M multiply/divide engine. Radix-2 shift-add multiply and
//   restoring divide over operand magnitudes, one step per cycle, with sign
//   fix-up on the final step. Divide-by-zero and signed overflow bypass the
//   iteration and land in DONE directly.
//   Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
//   product registered on the IDLE -> DONE transition; divides are unchanged.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          muldiv op present in EX (only honoured in IDLE)
//   i_kill           flush or op no longer active; abandon and drop result
//   i_ack            result consumed (EX advances); DONE -> IDLE
//   i_funct3, i_isW  operation select, 32-bit (W) variant
//   i_opA, i_opB     rs1 / rs2 operands
//   o_done, o_busy   engine in DONE / engine not IDLE
//   o_result         result register
module muldiv_unit
   import ex_muldiv_stage_pkg::*;
#(
   parameter int XLEN       = MD_XLEN,
   parameter int ITER_CNT_W = MD_ITER_CNT_W
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic            i_kill,
   input  logic            i_ack,
   input  logic [2:0]      i_funct3,
   input  logic            i_isW,
   input  logic [XLEN-1:0] i_opA,
   input  logic [XLEN-1:0] i_opB,
   output logic            o_done,
   output logic            o_busy,
   output logic [XLEN-1:0] o_result
);

   muldiv_state_t r_state, w_stateNext;

   logic [ITER_CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]       r_hi, r_lo, r_m, r_result;
   logic [2:0]            r_f3;
   logic                  r_isW, r_negQ, r_negR;

   logic            w_signedA, w_signedB, w_negA, w_negB, w_isDiv;
   logic            w_divZero, w_overflow, w_shortcut, w_lastStep, w_fits;
   logic [XLEN-1:0] w_aExt, w_bExt, w_magA, w_magB, w_minNeg, w_specialRes;
   logic [XLEN-1:0] w_hiNext, w_loNext, w_iterRes;
   logic [XLEN:0]   w_sum, w_shift, w_diff;

   function automatic logic [XLEN-1:0] sextW(input logic isW, input logic [XLEN-1:0] v);
      return isW ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // Turns raw magnitude results into the architectural value: sign fix-up,
   // high/low product half selection and W-variant sign extension.
   // For multiplies {hi,lo} is the product, for divides hi = rem, lo = quot.
   function automatic logic [XLEN-1:0] finishResult(input logic [2:0] f3, input logic isW,
                                                    input logic negQ, input logic negR,
                                                    input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   res;
      prod = negQ ? -{hi, lo} : {hi, lo};
      case (f3)
         F3M_MUL:                         res = prod[XLEN-1:0];
         F3M_MULH, F3M_MULHSU, F3M_MULHU: res = prod[2*XLEN-1:XLEN];
         F3M_DIV, F3M_DIVU:               res = negQ ? -lo : lo;
         default:                         res = negR ? -hi : hi;
      endcase
      return sextW(isW, res);
   endfunction

   // Operand preparation for the op waiting in IDLE: width/sign extension,
   // magnitudes, and detection of the cases that skip the iteration.
   always_comb begin
      w_signedA  = (i_funct3 == F3M_MULH) || (i_funct3 == F3M_MULHSU) ||
                   (i_funct3 == F3M_DIV)  || (i_funct3 == F3M_REM);
      w_signedB  = (i_funct3 == F3M_MULH) || (i_funct3 == F3M_DIV) || (i_funct3 == F3M_REM);
      w_aExt     = i_isW ? {{(XLEN-32){w_signedA & i_opA[31]}}, i_opA[31:0]} : i_opA;
      w_bExt     = i_isW ? {{(XLEN-32){w_signedB & i_opB[31]}}, i_opB[31:0]} : i_opB;
      w_negA     = w_signedA && w_aExt[XLEN-1];
      w_negB     = w_signedB && w_bExt[XLEN-1];
      w_magA     = w_negA ? -w_aExt : w_aExt;
      w_magB     = w_negB ? -w_bExt : w_bExt;
      w_isDiv    = f3IsDiv(i_funct3);
      w_minNeg   = i_isW ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      w_divZero  = w_isDiv && (w_bExt == '0);
      w_overflow = w_isDiv && w_signedA && (w_aExt == w_minNeg) && (w_bExt == '1);
      if (w_divZero) begin
         w_specialRes = i_funct3[1] ? w_aExt : '1;
      end else begin
         w_specialRes = i_funct3[1] ? '0 : w_aExt;
      end
      w_specialRes = sextW(i_isW, w_specialRes);
      w_shortcut   = w_divZero || w_overflow;
`ifdef MULDIV_FAST_MUL_EN
      w_shortcut   = w_shortcut || !w_isDiv;
`endif
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fastProd;
   logic [XLEN-1:0]   w_fastRes;

   // Single-cycle magnitude product, sign-fixed and selected like the iterative path
   always_comb begin
      w_fastProd = {{XLEN{1'b0}}, w_magA} * {{XLEN{1'b0}}, w_magB};
      w_fastRes  = finishResult(i_funct3, i_isW, w_negA ^ w_negB, 1'b0,
                                w_fastProd[2*XLEN-1:XLEN], w_fastProd[XLEN-1:0]);
   end
`endif

   // One radix-2 step. Multiply: add multiplicand when the multiplier LSB is
   // set, then shift {hi,lo} right. Divide: shift the partial remainder left,
   // subtract the divisor, keep the difference only when it did not borrow.
   always_comb begin
      w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_shift    = {r_hi, r_lo[XLEN-1]};
      w_diff     = w_shift - {1'b0, r_m};
      w_fits     = !w_diff[XLEN];
      if (f3IsDiv(r_f3)) begin
         w_hiNext = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
         w_loNext = {r_lo[XLEN-2:0], w_fits};
      end else begin
         w_hiNext = w_sum[XLEN:1];
         w_loNext = {w_sum[0], r_lo[XLEN-1:1]};
      end
      w_iterRes  = finishResult(r_f3, r_isW, r_negQ, r_negR, w_hiNext, w_loNext);
      w_lastStep = (r_cnt == ITER_CNT_W'(XLEN-1));
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= MD_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // FSM next-state logic; kill wins over completion in BUSY and DONE
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         MD_IDLE: if (i_start) w_stateNext = w_shortcut ? MD_DONE : MD_BUSY;
         MD_BUSY: begin
            if (i_kill)          w_stateNext = MD_IDLE;
            else if (w_lastStep) w_stateNext = MD_DONE;
         end
         MD_DONE: if (i_kill || i_ack) w_stateNext = MD_IDLE;
         default: w_stateNext = MD_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      o_done   = (r_state == MD_DONE);
      o_busy   = (r_state != MD_IDLE);
      o_result = r_result;
   end

   // Datapath: latch prepared operands on start, step while BUSY, capture the
   // result on the last step, and drop it whenever the op is killed.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_m      <= '0;
         r_f3     <= '0;
         r_isW    <= 1'b0;
         r_negQ   <= 1'b0;
         r_negR   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (i_start) begin
                  r_cnt  <= '0;
                  r_f3   <= i_funct3;
                  r_isW  <= i_isW;
                  r_negQ <= w_negA ^ w_negB;
                  r_negR <= w_negA;
                  r_hi   <= '0;
                  r_lo   <= w_isDiv ? w_magA : w_magB;
                  r_m    <= w_isDiv ? w_magB : w_magA;
                  if (w_divZero || w_overflow) begin
                     r_result <= w_specialRes;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (!w_isDiv) begin
                     r_result <= w_fastRes;
`endif
                  end else begin
                     r_result <= '0;
                  end
               end
            end
            MD_BUSY: begin
               if (i_kill) begin
                  r_cnt    <= '0;
                  r_result <= '0;
               end else begin
                  r_hi  <= w_hiNext;
                  r_lo  <= w_loNext;
                  r_cnt <= r_cnt + ITER_CNT_W'(1);
                  if (w_lastStep) r_result <= w_iterRes;
               end
            end
            MD_DONE: begin
               if (i_kill) r_result <= '0;
            end
            default: r_result <= '0;
         endcase
      end
   end

endmodule

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage
//   Execute stage output selection feeding MEM: effective address for
//   loads/stores, the combinational Alu result for other single-cycle ops,
//   or the iterative mul/div result; generates the EX stall.
//   Optional build macro MULDIV_FAST_MUL_EN (handled in muldiv_unit).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   inst                decoded instruction in EX
//   is_bubble           EX slot empty
//   op_trapped          instruction already trapped, behaves as a no-op
//   advance             EX instruction moves to MEM this cycle
//   flush               kill the EX instruction and any in-flight mul/div
//   op_a, op_b          forwarded rs1, rs2-or-immediate
//   store_src           forwarded rs2 for stores
//   alu_result          combinational Alu result
//   ex_data, ex_data2   result/address and store data to MEM
//   stall               EX needs more cycles
//   muldiv_busy         mul/div engine not IDLE
module ex_muldiv_stage
   import ex_muldiv_stage_pkg::*;
#(
   parameter int XLEN       = MD_XLEN,
   parameter int ITER_CNT_W = MD_ITER_CNT_W
) (
   input  logic            clk,
   input  logic            reset,
   input  decoded_inst_t   inst,
   input  logic            is_bubble,
   input  logic            op_trapped,
   input  logic            advance,
   input  logic            flush,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [XLEN-1:0] store_src,
   input  logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] ex_data,
   output logic [XLEN-1:0] ex_data2,
   output logic            stall,
   output logic            muldiv_busy
);

   logic            w_active, w_mdOp, w_mdStart, w_mdKill, w_mdDone;
   logic [XLEN-1:0] w_mdResult;

   // An op that is gone (bubble, trapped) or flushed must abandon the engine
   always_comb begin
      w_active  = !is_bubble && !op_trapped;
      w_mdOp    = w_active && inst.is_muldiv;
      w_mdStart = w_mdOp && !flush;
      w_mdKill  = flush || !w_mdOp;
   end

   muldiv_unit #(
      .XLEN       (XLEN),
      .ITER_CNT_W (ITER_CNT_W)
   ) u_muldiv (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_start  (w_mdStart),
      .i_kill   (w_mdKill),
      .i_ack    (advance),
      .i_funct3 (inst.funct3),
      .i_isW    (inst.alu_width_32),
      .i_opA    (op_a),
      .i_opB    (op_b),
      .o_done   (w_mdDone),
      .o_busy   (muldiv_busy),
      .o_result (w_mdResult)
   );

   // Result muxing and stall: a muldiv op stalls until its result is in DONE
   always_comb begin
      if (w_mdOp) begin
         ex_data = w_mdResult;
      end else if (inst.is_load || inst.is_store) begin
         ex_data = op_a + op_b;
      end else begin
         ex_data = alu_result;
      end
      ex_data2 = store_src;
      stall    = w_mdOp && !w_mdDone;
   end

   // A muldiv op still in IDLE always stalls, so the pipeline can never advance it
   assert property (@(posedge clk) disable iff (reset) !(w_mdStart && !muldiv_busy && advance))
      else $error("ex_muldiv_stage: advance asserted while muldiv op is still in IDLE");

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb_ex_muldiv_stage
//   Self-checking bench for ex_muldiv_stage. Expected results come from a
//   behavioural RV64M model and are queued when an op is driven, then popped
//   when EX releases the stall. Honours MULDIV_FAST_MUL_EN for mul latency.
module tb_ex_muldiv_stage;
   import ex_muldiv_stage_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_STALL = 1;
`else
   localparam int MUL_STALL = 65;
`endif
   localparam int ITER_STALL = 65;
   localparam int MAX_WAIT   = 200;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   decoded_inst_t inst = '0;
   logic          is_bubble = 1'b1;
   logic          op_trapped = 1'b0;
   logic          advance = 1'b0;
   logic          flush = 1'b0;
   logic [63:0]   op_a = '0, op_b = '0, store_src = '0, alu_result = '0;
   logic [63:0]   ex_data, ex_data2;
   logic          stall, muldiv_busy;

   typedef struct {
      logic [63:0] data;
      int          stallCycles;
   } expect_t;

   expect_t scoreboard[$];
   int      assertCount = 0;
   int      failCount = 0;

   ex_muldiv_stage dut (
      .clk         (clk),
      .reset       (reset),
      .inst        (inst),
      .is_bubble   (is_bubble),
      .op_trapped  (op_trapped),
      .advance     (advance),
      .flush       (flush),
      .op_a        (op_a),
      .op_b        (op_b),
      .store_src   (store_src),
      .alu_result  (alu_result),
      .ex_data     (ex_data),
      .ex_data2    (ex_data2),
      .stall       (stall),
      .muldiv_busy (muldiv_busy)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // Safety net in case the DUT wedges somewhere the bounded waits do not cover
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
      end
   endtask

   // Behavioural RV64M reference
   function automatic logic [63:0] refResult(input logic [2:0] f3, input logic isW,
                                             input logic [63:0] a, input logic [63:0] b);
      logic signed [63:0] sa, sb;
      logic signed [31:0] sa32, sb32;
      logic [31:0]        a32, b32, r32;
      logic [127:0]       pa, pb, prod;
      logic [63:0]        r;
      logic               ovf64, ovf32;
      sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
      ovf32 = (a32 == 32'h8000_0000) && (b32 == '1);
      r = '0; r32 = '0; pa = '0; pb = '0; prod = '0;
      if (isW) begin
         case (f3)
            F3M_DIV:  begin if (b32 == 0) r32 = '1; else if (ovf32) r32 = a32; else r32 = sa32 / sb32; end
            F3M_DIVU: begin if (b32 == 0) r32 = '1; else r32 = a32 / b32; end
            F3M_REM:  begin if (b32 == 0) r32 = a32; else if (ovf32) r32 = '0; else r32 = sa32 % sb32; end
            F3M_REMU: begin if (b32 == 0) r32 = a32; else r32 = a32 % b32; end
            default:  r32 = a32 * b32;
         endcase
         r = {{32{r32[31]}}, r32};
      end else begin
         case (f3)
            F3M_MUL:    r = a * b;
            F3M_MULH:   begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; prod = pa * pb; r = prod[127:64]; end
            F3M_MULHSU: begin pa = {{64{a[63]}}, a}; pb = {64'b0, b};       prod = pa * pb; r = prod[127:64]; end
            F3M_MULHU:  begin pa = {64'b0, a};       pb = {64'b0, b};       prod = pa * pb; r = prod[127:64]; end
            F3M_DIV:    begin if (b == 0) r = '1; else if (ovf64) r = a; else r = sa / sb; end
            F3M_DIVU:   begin if (b == 0) r = '1; else r = a / b; end
            F3M_REM:    begin if (b == 0) r = a; else if (ovf64) r = '0; else r = sa % sb; end
            default:    begin if (b == 0) r = a; else r = a % b; end
         endcase
      end
      return r;
   endfunction

   function automatic int refStall(input logic [2:0] f3, input logic isW,
                                   input logic [63:0] a, input logic [63:0] b);
      logic zero, ovf;
      if (!f3[2]) return MUL_STALL;
      zero = isW ? (b[31:0] == 0) : (b == 0);
      ovf  = (f3 == F3M_DIV || f3 == F3M_REM) &&
             (isW ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                  : (a == 64'h8000_0000_0000_0000 && b == '1));
      return (zero || ovf) ? 1 : ITER_STALL;
   endfunction

   // Drive one op into EX, wait (bounded) for the stall to drop, check the
   // popped expectation, optionally hold DONE, then advance it to MEM.
   task automatic applyStimulus(input string tag, input logic md, input logic ld, input logic st,
                                input logic [2:0] f3, input logic isW,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] alu, input logic [63:0] src, input int hold);
      expect_t e, got;
      int      cyc;
      if (md) begin
         e.data = refResult(f3, isW, a, b);
         e.stallCycles = refStall(f3, isW, a, b);
      end else if (ld || st) begin
         e.data = a + b;
         e.stallCycles = 0;
      end else begin
         e.data = alu;
         e.stallCycles = 0;
      end
      scoreboard.push_back(e);
      @(negedge clk);
      inst = '0;
      inst.is_muldiv = md;
      inst.is_load = ld;
      inst.is_store = st;
      inst.funct3 = f3;
      inst.alu_width_32 = isW;
      is_bubble = 1'b0;
      op_a = a; op_b = b; alu_result = alu; store_src = src;
      cyc = 0;
      #1;
      while (stall && cyc < MAX_WAIT) begin
         cyc++;
         @(negedge clk);
         #1;
      end
      got = scoreboard.pop_front();
      checkOutput({tag, "_stall"}, 64'(cyc), 64'(got.stallCycles));
      checkOutput({tag, "_data"}, ex_data, got.data);
      if (st) checkOutput({tag, "_data2"}, ex_data2, src);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         #1;
         checkOutput({tag, "_hold"}, ex_data, got.data);
      end
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      is_bubble = 1'b1;
      inst = '0;
   endtask

   initial begin
      logic [2:0]  f3;
      logic        isW;
      logic [63:0] a, b;

      $display("[TB] ex_muldiv_stage bench start");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("reset_stall", {63'b0, stall}, 64'd0);
      checkOutput("reset_busy", {63'b0, muldiv_busy}, 64'd0);

      applyStimulus("add",   1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 64'd5, 64'd6, 64'h1234, 64'd0, 0);
      applyStimulus("load",  1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 64'h1000, 64'h28, 64'h0, 64'd0, 0);
      applyStimulus("store", 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF8,
                    64'h0, 64'hDEAD_BEEF_0BAD_F00D, 0);

      applyStimulus("divu",      1'b1, 1'b0, 1'b0, F3M_DIVU, 1'b0, 64'd100, 64'd7, 64'h0, 64'd0, 5);
      applyStimulus("remu",      1'b1, 1'b0, 1'b0, F3M_REMU, 1'b0, 64'd100, 64'd7, 64'h0, 64'd0, 0);
      applyStimulus("div_ovf",   1'b1, 1'b0, 1'b0, F3M_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 64'd0, 0);
      applyStimulus("divw_zero", 1'b1, 1'b0, 1'b0, F3M_DIV,  1'b1, 64'd5, 64'd0, 64'h0, 64'd0, 0);
      applyStimulus("mulhu",     1'b1, 1'b0, 1'b0, F3M_MULHU, 1'b0, '1, 64'd2, 64'h0, 64'd0, 0);
      applyStimulus("mulw",      1'b1, 1'b0, 1'b0, F3M_MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'h0, 64'd0, 0);
      applyStimulus("div_neg",   1'b1, 1'b0, 1'b0, F3M_DIV,  1'b0, 64'd1000, -64'sd3, 64'h0, 64'd0, 0);
      applyStimulus("rem_neg",   1'b1, 1'b0, 1'b0, F3M_REM,  1'b0, -64'sd1000, 64'd7, 64'h0, 64'd0, 0);

      // Flush a signed divide on cycle 20 of its life
      @(negedge clk);
      inst = '0; inst.is_muldiv = 1'b1; inst.funct3 = F3M_DIV;
      op_a = 64'd1000; op_b = -64'sd3; is_bubble = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      checkOutput("flush_busy_before", {63'b0, muldiv_busy}, 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      is_bubble = 1'b1;
      #1;
      checkOutput("flush_busy_after", {63'b0, muldiv_busy}, 64'd0);
      checkOutput("flush_stall_after", {63'b0, stall}, 64'd0);
      applyStimulus("divu_post_flush", 1'b1, 1'b0, 1'b0, F3M_DIVU, 1'b0, 64'd9, 64'd3, 64'h0, 64'd0, 0);

      // Reset in the middle of BUSY
      @(negedge clk);
      inst = '0; inst.is_muldiv = 1'b1; inst.funct3 = F3M_DIVU;
      op_a = 64'd100; op_b = 64'd7; is_bubble = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checkOutput("reset_mid_busy_before", {63'b0, muldiv_busy}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      is_bubble = 1'b1;
      inst = '0;
      #1;
      checkOutput("reset_mid_busy_after", {63'b0, muldiv_busy}, 64'd0);
      checkOutput("reset_mid_stall_after", {63'b0, stall}, 64'd0);
      applyStimulus("mulh_post_reset", 1'b1, 1'b0, 1'b0, F3M_MULH, 1'b0, -64'sd3, 64'd5, 64'h0, 64'd0, 0);

      // Random ops through the scoreboard
      for (int i = 0; i < 8; i++) begin
         f3  = 3'($urandom_range(0, 7));
         isW = (f3 == F3M_MUL || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
         a   = {$urandom, $urandom};
         b   = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom} >> $urandom_range(0, 60);
         applyStimulus($sformatf("rand%0d", i), 1'b1, 1'b0, 1'b0, f3, isW, a, b, 64'h0, 64'd0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
